h_u_rca4_serial_add: RTL and testbench

Digit-serial unsigned adder that reuses one 4-bit ripple-carry slice (ha/fa chain with carry-in) over several cycles to add wide operands nibble by nibble. It sits directly upstream of the wide-result consumers and chains 4-bit adder slices in time instead of space. A registered carry links successive nibbles. A valid/ready handshake on each side lets it slot into streaming datapaths.

---
 rtl/h_u_rca4_serial_add.sv | 167 ++++++++++++++++
 tb/tb_h_u_rca4_serial_add.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_u_rca4_serial_add.sv
// h_u_rca4_serial_add
// Digit-serial unsigned adder. One 4-bit ripple-carry slice (four full
// adders, carry-in live) is reused over WORDS cycles to add two
// 4*WORDS-bit operands nibble by nibble. A registered carry links
// successive nibbles. Both sides use a valid/ready handshake.
//
// Optional build macro: H_U_RCA4_SERIAL_SIGNED_OVF_EN
//   When defined, the module gets an extra output port "ovf". It reports
//   the two's-complement overflow of a+b and follows the same rules as "out".
//
// Legal WORDS range: 1..16.
module h_u_rca4_serial_add #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WORDS-1:0]   a,
  input  logic [4*WORDS-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
  output logic                 ovf,
`endif
  output logic [4*WORDS:0]     out
);

  localparam int W  = 4 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    res_sh;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [W:0]      out_q;
  logic            last;

  // Ripple-carry slice signals.
  // c[i] is the carry into bit i, so c[3] is the carry into the nibble MSB.
  logic [3:0]      sum4;
  logic [4:0]      c;
  logic [W+3:0]    res_cat;
  logic [W-1:0]    res_next;

  assign last = (cnt == LAST);

  // 4-bit slice: all four bits are full adders because the carry-in is live.
  assign c[0] = carry;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic p;
    assign p       = a_sh[i] ^ b_sh[i];
    assign sum4[i] = p ^ c[i];
    assign c[i+1]  = (a_sh[i] & b_sh[i]) | (c[i] & p);
  end

  // The new nibble enters the result register from the top, and the rest
  // shifts down. Concatenating first keeps this legal when WORDS == 1.
  assign res_cat  = {sum4, res_sh};
  assign res_next = res_cat[W+3:4];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_next unassigned
    // (that would infer a latch).
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs, decoded from the state register only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand and partial-result shift registers.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are deliberately not reset. They are
    // always loaded or fully overwritten before their contents are used, so
    // a reset would only add fan-out on rst.
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_sh <= a;
          b_sh <= b;
        end
      end
      RUN: begin
        a_sh   <= a_sh >> 4;
        b_sh   <= b_sh >> 4;
        res_sh <= res_next;
      end
      default: ;
    endcase
  end

  // Control datapath: carry, nibble counter, and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= c[4];
          cnt   <= cnt + 1'b1;
          if (last) begin
            out_q <= {c[4], res_next};
          end
        end
        default: ;
      endcase
    end
  end

  assign out = out_q;

`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
  logic ovf_q;

  // Signed overflow is captured on the last nibble, together with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= c[3] ^ c[4];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_h_u_rca4_serial_add.sv
// Self-checking bench for h_u_rca4_serial_add.
// It instantiates two copies: a WORDS=4 instance for most tests and a WORDS=1 instance.
// The reference model is plain integer addition of the operands.
module tb_h_u_rca4_serial_add;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out;

  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [4:0]  out1;

`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
  logic        ovf;
  logic        ovf1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  h_u_rca4_serial_add #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
    .ovf       (ovf),
`endif
    .out       (out)
  );

  h_u_rca4_serial_add #(.WORDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
    .ovf       (ovf1),
`endif
    .out       (out1)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record one comparison. Print a FAIL line when the values differ.
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: unsigned sum, W+1 bits wide.
  function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Reference model: two's-complement overflow.
  // Overflow occurs when both operands have the same sign and the sum's sign differs.
  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] s;
    s = x + y;
    return (x[15] == y[15]) && (s[15] != x[15]);
  endfunction

  // Accept one operand pair on the WORDS=4 instance and wait for the result.
  // On return, out_valid is high and the output handshake has not yet happened.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input string nm);
    int lat;
    lat = 0;
    while (in_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cmp({nm, "_in_ready_drop"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    cmp({nm, "_latency"}, lat, 32'd4);
    cmp({nm, "_out"}, 32'(out), 32'(ref_sum(av, bv)));
`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
    cmp({nm, "_ovf"}, 32'(ovf), 32'(ref_ovf(av, bv)));
`endif
  endtask

  // Complete the output handshake, then confirm the block is idle again.
  task automatic finish_op(input string nm);
    out_ready = 1'b1;
    tick();
    cmp({nm, "_out_valid_low"}, 32'(out_valid), 32'd0);
    cmp({nm, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cmp("reset_out_valid", 32'(out_valid), 32'd0);
    cmp("reset_out", 32'(out), 32'd0);
    cmp("reset_in_ready", 32'(in_ready), 32'd1);
    cmp("reset_w1_out", 32'(out1), 32'd0);
    cmp("reset_w1_in_ready", 32'(in_ready1), 32'd1);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_op(16'h1234, 16'h4321, "basic");
    cmp("basic_exp_const", 32'(out), 32'h05555);
    finish_op("basic");
    cmp("basic_out_held", 32'(out), 32'h05555);
  endtask

  task automatic test_carry();
    out_ready = 1'b1;
    do_op(16'hFFFF, 16'h0001, "ripple");
    cmp("ripple_const", 32'(out), 32'h10000);
    finish_op("ripple");
    do_op(16'hFFFF, 16'hFFFF, "allones");
    cmp("allones_const", 32'(out), 32'h1FFFE);
    finish_op("allones");
  endtask

  task automatic test_backpressure();
    logic [16:0] held;
    int          bad_out;
    int          bad_ctl;
    out_ready = 1'b0;
    do_op(16'h00F0, 16'h0F10, "bp");
    held    = out;
    bad_out = 0;
    bad_ctl = 0;
    // Hold off downstream for 10 cycles while pulsing new operands,
    // which must be ignored.
    for (int i = 0; i < 10; i++) begin
      a        = 16'($urandom);
      b        = 16'($urandom);
      in_valid = i[0];
      tick();
      if (out !== held) bad_out++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) bad_ctl++;
    end
    in_valid = 1'b0;
    cmp("bp_out_stable", bad_out, 32'd0);
    cmp("bp_ctl_stable", bad_ctl, 32'd0);
    cmp("bp_out_value", 32'(out), 32'h01000);
    finish_op("bp");
    tick();
    cmp("bp_no_stray_accept", 32'(in_ready), 32'd1);
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    a        = 16'hAAAA;
    b        = 16'h5555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Now in the first RUN cycle. Advance to the second RUN cycle, then reset.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("midrst_out_valid", 32'(out_valid), 32'd0);
    cmp("midrst_out", 32'(out), 32'd0);
    cmp("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    cmp("midrst_no_result", seen, 32'd0);
    do_op(16'h0001, 16'h0002, "after_rst");
    cmp("after_rst_const", 32'(out), 32'h00003);
    finish_op("after_rst");
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    a        = 16'h0003;
    b        = 16'h0004;
    in_valid = 1'b1;
    tick();
    // Change operands while RUN is in progress. The block must ignore them
    // until it is idle again.
    a = 16'h8000;
    b = 16'h8000;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    cmp("b2b_first_latency", lat, 32'd4);
    cmp("b2b_first_out", 32'(out), 32'h00007);
`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
    cmp("b2b_first_ovf", 32'(ovf), 32'd0);
`endif
    tick();  // output handshake edge
    cmp("b2b_idle_after_hs", 32'(in_ready), 32'd1);
    tick();  // second accept edge
    in_valid = 1'b0;
    cmp("b2b_second_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    cmp("b2b_second_latency", lat, 32'd4);
    cmp("b2b_second_out", 32'(out), 32'h10000);
`ifdef H_U_RCA4_SERIAL_SIGNED_OVF_EN
    cmp("b2b_second_ovf", 32'(ovf), 32'd1);
`endif
    finish_op("b2b");
  endtask

  task automatic test_words1();
    int lat;
    logic [4:0] exp;
    out_ready1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        a1 = 4'hF;
        b1 = 4'h1;
      end else begin
        a1 = 4'($urandom);
        b1 = 4'($urandom);
      end
      exp = {1'b0, a1} + {1'b0, b1};
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      cmp("w1_latency", lat, 32'd1);
      cmp("w1_out", 32'(out1), 32'(exp));
      tick();
      cmp("w1_idle", 32'(in_ready1), 32'd1);
    end
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      // Occasionally force boundary patterns.
      case ($urandom_range(0, 9))
        0: ra = 16'hFFFF;
        1: rb = 16'hFFFF;
        2: ra = 16'h0000;
        default: ;
      endcase
      out_ready = 1'b0;
      do_op(ra, rb, "rand");
      // Random downstream stall before the handshake.
      for (int s = $urandom_range(0, 2); s > 0; s--) tick();
      cmp("rand_held", 32'(out), 32'(ref_sum(ra, rb)));
      finish_op("rand");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    a1         = '0;
    b1         = '0;
    out_ready1 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_words1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
